// File: rtl/rtr_ovc_scheduler_pkg.sv
// rtr_ovc_scheduler_pkg: shared router constants (flow-control/buffer types, lock state, payload slicing)
package rtr_ovc_scheduler_pkg;
  typedef enum logic [1:0] {FC_CREDIT, FC_ON_OFF} fc_type_e;
  typedef enum logic [1:0] {BUF_STATIC, BUF_DYNAMIC} buf_mgmt_e;
  typedef enum logic {LOCK_UNLOCKED, LOCK_LOCKED} lock_state_e;
  localparam int LOCK_PACKET = 1;
  // VC0 occupies the MSBs of a packed per-VC payload bus
  function automatic int flit_data_lsb(input int vc, input int num_vcs, input int width);
    return (num_vcs - 1 - vc) * width;
  endfunction
endpackage

// File: rtl/rtr_ovc_scheduler_c_rr_arbiter.sv
// c_rr_arbiter: masked round-robin arbiter over a one-hot priority pointer
//   req  - request vector
//   prio - one-hot pointer; the search starts at this position
//   gnt  - one-hot grant, or zero when nothing requests
module c_rr_arbiter #(
  parameter int num_ports = 4
) (
  input  logic [num_ports-1:0] req,
  input  logic [num_ports-1:0] prio,
  output logic [num_ports-1:0] gnt
);
  logic [num_ports-1:0] mreq, pick;
  always_comb begin
    mreq = req & ~(prio - 1'b1);
    pick = |mreq ? mreq : req;
    gnt  = pick & (~pick + 1'b1);
  end
endmodule

// File: rtl/rtr_ovc_scheduler.sv
// rtr_ovc_scheduler: per-output-port round-robin flit scheduler with optional packet lock
//   clk, reset (async, active-low)
//   req_*_ovc    - per-VC offered flit (valid/head/tail/payload, VC0 payload in MSBs)
//   full_ovc     - per-VC no-credit flag from the tracker
//   gnt_ovc      - combinational one-hot pop strobe
//   flit_*       - registered flit to channel and tracker
//   locked       - a packet holds the port
//   error        - sticky head/body ordering violation
module rtr_ovc_scheduler
  import rtr_ovc_scheduler_pkg::*;
#(
  parameter int num_vcs         = 4,
  parameter int flit_data_width = 32,
  parameter int packet_lock     = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [num_vcs-1:0]                 req_ovc,
  input  logic [num_vcs-1:0]                 req_head_ovc,
  input  logic [num_vcs-1:0]                 req_tail_ovc,
  input  logic [num_vcs*flit_data_width-1:0] req_data_ovc,
  input  logic [num_vcs-1:0]                 full_ovc,
  output logic [num_vcs-1:0]                 gnt_ovc,
  output logic                               flit_valid,
  output logic                               flit_head,
  output logic                               flit_tail,
  output logic [num_vcs-1:0]                 flit_sel_ovc,
  output logic [flit_data_width-1:0]         flit_data,
  output logic                               locked,
  output logic                               error
);
  localparam logic [num_vcs-1:0] VC0 = num_vcs'(1);
  lock_state_e state_q, state_d;
  logic [num_vcs-1:0] lock_vc_q, lock_vc_d, prio_q, open_q, open_d, elig, arb_gnt;
  logic [flit_data_width-1:0] g_data;
  logic any_gnt, g_head, g_tail, g_open, err_now;

  c_rr_arbiter #(.num_ports(num_vcs)) u_arb (
    .req  (elig),
    .prio (prio_q),
    .gnt  (arb_gnt)
  );

  assign locked = state_q == LOCK_LOCKED;

  // no pops while held in reset, since upstream buffers reset alongside
  always_comb begin
    elig    = req_ovc & ~full_ovc & (locked ? lock_vc_q : '1);
    gnt_ovc = reset ? arb_gnt : '0;
    any_gnt = |gnt_ovc;
    g_head  = |(gnt_ovc & req_head_ovc);
    g_tail  = |(gnt_ovc & req_tail_ovc);
    g_open  = |(gnt_ovc & open_q);
    err_now = any_gnt & (g_head == g_open);
    g_data  = '0;
    for (int v = 0; v < num_vcs; v++)
      if (gnt_ovc[v]) g_data |= req_data_ovc[flit_data_lsb(v, num_vcs, flit_data_width) +: flit_data_width];
    open_d = g_tail ? open_q & ~gnt_ovc : g_head ? open_q | gnt_ovc : open_q;
  end

  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    if (packet_lock == LOCK_PACKET && any_gnt) begin
      if (state_q == LOCK_UNLOCKED && g_head && !g_tail) begin
        state_d   = LOCK_LOCKED;
        lock_vc_d = gnt_ovc;
      end else if (state_q == LOCK_LOCKED && g_tail) begin
        state_d   = LOCK_UNLOCKED;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LOCK_UNLOCKED;
      lock_vc_q    <= '0;
      prio_q       <= VC0;
      open_q       <= '0;
      error        <= 1'b0;
      flit_valid   <= 1'b0;
      flit_head    <= 1'b0;
      flit_tail    <= 1'b0;
      flit_sel_ovc <= '0;
      flit_data    <= '0;
    end else begin
      state_q      <= state_d;
      lock_vc_q    <= lock_vc_d;
      prio_q       <= any_gnt ? {gnt_ovc[num_vcs-2:0], gnt_ovc[num_vcs-1]} : prio_q;
      open_q       <= open_d;
      error        <= error | err_now;
      flit_valid   <= any_gnt;
      flit_head    <= g_head;
      flit_tail    <= g_tail;
      flit_sel_ovc <= gnt_ovc;
      flit_data    <= g_data;
    end
  end
endmodule

// File: tb/tb_rtr_ovc_scheduler.sv
// tb_rtr_ovc_scheduler: directed self-checking bench for rtr_ovc_scheduler
module tb_rtr_ovc_scheduler;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] req_ovc = '0, req_head_ovc = '0, req_tail_ovc = '0, full_ovc = '0;
  logic [N*W-1:0] req_data_ovc = {32'hD0, 32'hD1, 32'hD2, 32'hD3};
  logic [N-1:0] gnt_ovc, flit_sel_ovc;
  logic flit_valid, flit_head, flit_tail, locked, error;
  logic [W-1:0] flit_data;
  int errors = 0;
  int checks = 0;

  rtr_ovc_scheduler #(.num_vcs(N), .flit_data_width(W), .packet_lock(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_ovc      (req_ovc),
    .req_head_ovc (req_head_ovc),
    .req_tail_ovc (req_tail_ovc),
    .req_data_ovc (req_data_ovc),
    .full_ovc     (full_ovc),
    .gnt_ovc      (gnt_ovc),
    .flit_valid   (flit_valid),
    .flit_head    (flit_head),
    .flit_tail    (flit_tail),
    .flit_sel_ovc (flit_sel_ovc),
    .flit_data    (flit_data),
    .locked       (locked),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] h, input logic [3:0] t, input logic [3:0] f);
    req_ovc = r;
    req_head_ovc = h;
    req_tail_ovc = t;
    full_ovc = f;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(4'hF, 4'hF, 4'hF, 4'h0);
    check("rst_gnt", 32'(gnt_ovc), 'h0);
    tick;
    check("rst_valid", 32'(flit_valid), 'h0);
    check("rst_sel", 32'(flit_sel_ovc), 'h0);
    check("rst_data", flit_data, 'h0);
    check("rst_locked", 32'(locked), 'h0);
    check("rst_error", 32'(error), 'h0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(4'hF, 4'hF, 4'hF, 4'h0);
      check("rr_gnt", 32'(gnt_ovc), 32'(4'b1 << (i % 4)));
      tick;
      check("rr_sel", 32'(flit_sel_ovc), 32'(4'b1 << (i % 4)));
      check("rr_data", flit_data, 32'(32'hD0 + i % 4));
      check("rr_valid", 32'(flit_valid), 'h1);
    end
    drive(4'h0, 4'h0, 4'h0, 4'h0);
    tick;
    check("idle_valid", 32'(flit_valid), 'h0);
    drive(4'b0110, 4'b0110, 4'b0100, 4'h0);
    check("pk_head_gnt", 32'(gnt_ovc), 'h2);
    tick;
    check("pk_head_locked", 32'(locked), 'h1);
    check("pk_head_flag", 32'(flit_head), 'h1);
    drive(4'b0110, 4'b0100, 4'b0100, 4'h0);
    check("pk_body_gnt", 32'(gnt_ovc), 'h2);
    tick;
    check("pk_body_locked", 32'(locked), 'h1);
    drive(4'b0110, 4'b0100, 4'b0110, 4'h0);
    check("pk_tail_gnt", 32'(gnt_ovc), 'h2);
    tick;
    check("pk_tail_flag", 32'(flit_tail), 'h1);
    check("pk_unlocked", 32'(locked), 'h0);
    drive(4'b0100, 4'b0100, 4'b0100, 4'h0);
    check("pk_vc2_gnt", 32'(gnt_ovc), 'h4);
    tick;
    check("pk_vc2_data", flit_data, 'hD2);
    check("pk_no_error", 32'(error), 'h0);
    drive(4'b0110, 4'b0110, 4'b0100, 4'h0);
    check("st_head_gnt", 32'(gnt_ovc), 'h2);
    tick;
    check("st_locked", 32'(locked), 'h1);
    repeat (2) begin
      drive(4'b0110, 4'b0100, 4'b0100, 4'b0010);
      check("st_stall_gnt", 32'(gnt_ovc), 'h0);
      tick;
      check("st_stall_valid", 32'(flit_valid), 'h0);
      check("st_stall_locked", 32'(locked), 'h1);
    end
    drive(4'b0110, 4'b0100, 4'b0100, 4'h0);
    check("st_body_gnt", 32'(gnt_ovc), 'h2);
    tick;
    drive(4'b0110, 4'b0100, 4'b0110, 4'h0);
    check("st_tail_gnt", 32'(gnt_ovc), 'h2);
    tick;
    check("st_unlocked", 32'(locked), 'h0);
    drive(4'b0100, 4'b0100, 4'b0100, 4'h0);
    check("st_vc2_gnt", 32'(gnt_ovc), 'h4);
    tick;
    repeat (3) begin
      drive(4'hF, 4'hF, 4'hF, 4'b1110);
      check("full_gnt", 32'(gnt_ovc), 'h1);
      tick;
      check("full_sel", 32'(flit_sel_ovc), 'h1);
    end
    drive(4'b1000, 4'h0, 4'h0, 4'h0);
    check("err_gnt", 32'(gnt_ovc), 'h8);
    check("err_before", 32'(error), 'h0);
    tick;
    check("err_fwd_valid", 32'(flit_valid), 'h1);
    check("err_fwd_sel", 32'(flit_sel_ovc), 'h8);
    check("err_rise", 32'(error), 'h1);
    drive(4'h0, 4'h0, 4'h0, 4'h0);
    tick;
    check("err_sticky", 32'(error), 'h1);
    drive(4'b0100, 4'b0100, 4'b0000, 4'h0);
    check("rl_head_gnt", 32'(gnt_ovc), 'h4);
    tick;
    check("rl_locked", 32'(locked), 'h1);
    reset = 1'b0;
    #1;
    check("rl_valid", 32'(flit_valid), 'h0);
    check("rl_sel", 32'(flit_sel_ovc), 'h0);
    check("rl_data", flit_data, 'h0);
    check("rl_lock_clr", 32'(locked), 'h0);
    check("rl_err_clr", 32'(error), 'h0);
    check("rl_gnt", 32'(gnt_ovc), 'h0);
    drive(4'h0, 4'h0, 4'h0, 4'h0);
    tick;
    reset = 1'b1;
    drive(4'hF, 4'hF, 4'hF, 4'h0);
    check("rl_first_gnt", 32'(gnt_ovc), 'h1);
    tick;
    check("rl_first_sel", 32'(flit_sel_ovc), 'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
